// File: rtl/phase_gen_pkg.sv
// Shared defaults and direction encoding for the multi-channel phase generator.
package phase_gen_pkg;

    localparam int FREQ_W_DEF  = 13;
    localparam int PHASE_W_DEF = 8;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

endpackage

// File: rtl/phase_gen_chan.sv
// One phase-generator channel: shadow/active config, period divider, phase counter and wrap flag.
module phase_gen_chan
    import phase_gen_pkg::*;
#(
    parameter int FREQ_W  = FREQ_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [FREQ_W-1:0]  wr_freq,
    input  logic               wr_dir,
    input  logic               sync,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap,
    output logic               pending
);

    logic [FREQ_W-1:0]  shadow_freq, shadow_freq_n;
    logic               shadow_dir, shadow_dir_n;
    logic               pending_n;
    logic [FREQ_W-1:0]  active_freq, active_freq_n;
    logic               active_dir, active_dir_n;
    logic [FREQ_W-1:0]  cnt, cnt_n;
    logic [PHASE_W-1:0] phase_n;
    logic               wrap_n;

    logic               idle;
    logic               tick;
    logic               apply;
    logic [PHASE_W:0]   stepped;

    // Step the phase by one in the given direction; MSB of the result flags a wrap.
    function automatic logic [PHASE_W:0] phase_step(input logic [PHASE_W-1:0] p,
                                                    input logic dir);
        logic [PHASE_W-1:0] n;
        logic               w;
        if (dir == DIR_DN) begin
            n = p - 1'b1;
            w = (p == '0);
        end else begin
            n = p + 1'b1;
            w = &p;
        end
        return {w, n};
    endfunction

    assign idle    = (active_freq == '0);
    assign tick    = !idle && (cnt == active_freq);
    // A pending config lands on any boundary: sync, an idle channel, or a period tick.
    assign apply   = pending && (sync || idle || tick);
    assign stepped = phase_step(phase, active_dir);

    // Next-state: sync beats tick beats counting; config apply uses the pre-edge shadow.
    always_comb begin
        shadow_freq_n = shadow_freq;
        shadow_dir_n  = shadow_dir;
        pending_n     = pending;
        active_freq_n = active_freq;
        active_dir_n  = active_dir;
        cnt_n         = cnt;
        phase_n       = phase;
        wrap_n        = 1'b0;

        if (sync || idle) begin
            cnt_n   = '0;
            phase_n = '0;
        end else if (tick) begin
            cnt_n = '0;
            if (apply && (shadow_freq == '0)) begin
                phase_n = '0;
            end else begin
                phase_n = stepped[PHASE_W-1:0];
                wrap_n  = stepped[PHASE_W];
            end
        end else begin
            cnt_n = cnt + 1'b1;
        end

        if (apply) begin
            active_freq_n = shadow_freq;
            active_dir_n  = shadow_dir;
            pending_n     = 1'b0;
        end

        // A write on the applying edge stays pending for the following boundary.
        if (wr_en) begin
            shadow_freq_n = wr_freq;
            shadow_dir_n  = wr_dir;
            pending_n     = 1'b1;
        end
    end

    // Channel state register; reset leaves the channel disabled with nothing pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_freq <= '0;
            shadow_dir  <= 1'b0;
            pending     <= 1'b0;
            active_freq <= '0;
            active_dir  <= 1'b0;
            cnt         <= '0;
            phase       <= '0;
            wrap        <= 1'b0;
        end else begin
            shadow_freq <= shadow_freq_n;
            shadow_dir  <= shadow_dir_n;
            pending     <= pending_n;
            active_freq <= active_freq_n;
            active_dir  <= active_dir_n;
            cnt         <= cnt_n;
            phase       <= phase_n;
            wrap        <= wrap_n;
        end
    end

endmodule

// File: rtl/multi_phase_gen.sv
// Multi-channel frequency-to-phase generator: write decode, channel array, output packing.
module multi_phase_gen
    import phase_gen_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int FREQ_W   = FREQ_W_DEF,
    parameter int PHASE_W  = PHASE_W_DEF,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [CH_W-1:0]             wr_ch,
    input  logic [FREQ_W-1:0]           wr_freq,
    input  logic                        wr_dir,
    input  logic                        sync,
    output logic [CHANNELS*PHASE_W-1:0] phase,
    output logic [CHANNELS-1:0]         wrap,
    output logic [CHANNELS-1:0]         pending
);

    logic [CHANNELS-1:0] wr_sel;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        // Only an exact address match selects a channel, so out-of-range writes fall through.
        assign wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

        phase_gen_chan #(
            .FREQ_W  (FREQ_W),
            .PHASE_W (PHASE_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_sel[i]),
            .wr_freq (wr_freq),
            .wr_dir  (wr_dir),
            .sync    (sync),
            .phase   (phase[i*PHASE_W +: PHASE_W]),
            .wrap    (wrap[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_multi_phase_gen.sv
// Self-checking bench for multi_phase_gen: directed scenarios plus random traffic vs a reference model.
module tb_multi_phase_gen;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_ch = '0;
    logic [12:0] wr_freq = '0;
    logic        wr_dir = 1'b0;
    logic        sync = 1'b0;
    logic [31:0] phase;
    logic [3:0]  wrap;
    logic [3:0]  pending;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, one entry per channel
    int m_shf[NCH], m_shd[NCH], m_pend[NCH], m_actf[NCH], m_actd[NCH];
    int m_age[NCH], m_ph[NCH], m_wrap[NCH];

    multi_phase_gen #(
        .CHANNELS (4),
        .FREQ_W   (13),
        .PHASE_W  (8),
        .CH_W     (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_freq (wr_freq),
        .wr_dir  (wr_dir),
        .sync    (sync),
        .phase   (phase),
        .wrap    (wrap),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_shf[c] = 0; m_shd[c] = 0; m_pend[c] = 0; m_actf[c] = 0; m_actd[c] = 0;
            m_age[c] = 0; m_ph[c] = 0; m_wrap[c] = 0;
        end
    endtask

    // One clock edge of behaviour: boundaries apply the old shadow, then any write lands.
    task automatic model_step(input bit we, input int ch, input int fr, input int dr, input bit sy);
        for (int c = 0; c < NCH; c++) begin
            bit app;
            int s;
            app = 0;
            m_wrap[c] = 0;
            if (sy || m_actf[c] == 0) begin
                m_age[c] = 0;
                m_ph[c]  = 0;
                app = (m_pend[c] != 0);
            end else if (m_age[c] == m_actf[c]) begin
                m_age[c] = 0;
                app = (m_pend[c] != 0);
                if (app && m_shf[c] == 0) begin
                    m_ph[c] = 0;
                end else begin
                    s = m_ph[c] + ((m_actd[c] != 0) ? -1 : 1);
                    m_wrap[c] = (s < 0 || s > 255) ? 1 : 0;
                    m_ph[c] = (s + 256) % 256;
                end
            end else begin
                m_age[c]++;
            end
            if (app) begin
                m_actf[c] = m_shf[c];
                m_actd[c] = m_shd[c];
                m_pend[c] = 0;
            end
            if (we && ch == c) begin
                m_shf[c] = fr;
                m_shd[c] = dr;
                m_pend[c] = 1;
            end
        end
    endtask

    function automatic logic [31:0] exp_phase();
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c*8 +: 8] = 8'(m_ph[c]);
        return v;
    endfunction

    function automatic logic [31:0] exp_bits(input bit sel_wrap);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c] = sel_wrap ? (m_wrap[c] != 0) : (m_pend[c] != 0);
        return v;
    endfunction

    // Advance one clock, update the model, compare all outputs, then drop one-shot inputs.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(wr_en, int'(wr_ch), int'(wr_freq), int'(wr_dir), sync);
        #1;
        chk("phase", phase, exp_phase());
        chk("wrap", {28'b0, wrap}, exp_bits(1));
        chk("pending", {28'b0, pending}, exp_bits(0));
        wr_en = 1'b0;
        sync  = 1'b0;
    endtask

    task automatic write(input int ch, input int fr, input int dr);
        wr_en   = 1'b1;
        wr_ch   = 3'(ch);
        wr_freq = 13'(fr);
        wr_dir  = 1'(dr);
    endtask

    initial begin
        logic [7:0] ph0;
        bit seen;

        // Scenario 1: reset release, everything idle at zero
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_phase", phase, 32'h0);
        chk("rst_wrap", {28'b0, wrap}, 32'h0);
        chk("rst_pending", {28'b0, pending}, 32'h0);
        repeat (100) step();
        chk("idle_phase", phase, 32'h0);

        // Scenario 2: start ch0 at freq 3, up
        write(0, 3, 0);
        step();
        chk("s2_pend_t1", {31'b0, pending[0]}, 32'h1);
        step();
        chk("s2_pend_t2", {31'b0, pending[0]}, 32'h0);
        repeat (3) step();
        chk("s2_ph_t4", {24'b0, phase[7:0]}, 32'h0);
        step();
        chk("s2_ph_t5", {24'b0, phase[7:0]}, 32'h1);
        repeat (4) step();
        chk("s2_ph_t9", {24'b0, phase[7:0]}, 32'h2);
        chk("s2_others", {8'b0, phase[31:8]}, 32'h0);

        // Scenario 3: shorten period two cycles after a tick
        ph0 = phase[7:0];
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (phase[7:0] != ph0) seen = 1;
        end
        chk("s3_tick_seen", {31'b0, seen}, 32'h1);
        ph0 = phase[7:0];
        step();
        write(0, 1, 0);
        step();
        step();
        chk("s3_ph_t3", {24'b0, phase[7:0]}, {24'b0, ph0});
        step();
        chk("s3_ph_t4", {24'b0, phase[7:0]}, {24'b0, 8'(ph0 + 8'd1)});
        chk("s3_pend_clr", {31'b0, pending[0]}, 32'h0);
        step();
        step();
        chk("s3_ph_t6", {24'b0, phase[7:0]}, {24'b0, 8'(ph0 + 8'd2)});

        // Scenario 4: ch1 freq 1 up through a full wrap, then reverse direction
        write(1, 1, 0);
        seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            step();
            if (wrap[1]) seen = 1;
        end
        chk("s4_wrap_up", {31'b0, seen}, 32'h1);
        chk("s4_ph_at_wrap", {24'b0, phase[15:8]}, 32'h0);
        write(1, 1, 1);
        step();
        chk("s4_wrap_1cyc", {31'b0, wrap[1]}, 32'h0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (wrap[1]) seen = 1;
        end
        chk("s4_wrap_dn", {31'b0, seen}, 32'h1);
        chk("s4_ph_dn", {24'b0, phase[15:8]}, 32'hff);

        // Scenario 5: three channels at different periods, then sync with a pending write
        write(2, 5, 0);
        step();
        write(0, 3, 0);
        step();
        repeat (13) step();
        write(2, 2, 0);
        step();
        sync = 1'b1;
        step();
        chk("s5_phase", phase, 32'h0);
        chk("s5_wrap", {28'b0, wrap}, 32'h0);
        chk("s5_pend", {31'b0, pending[2]}, 32'h0);
        repeat (12) step();

        // Scenario 6a: disable a running channel
        write(0, 0, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (!pending[0]) seen = 1;
        end
        chk("s6_dis_applied", {31'b0, seen}, 32'h1);
        chk("s6_dis_phase", {24'b0, phase[7:0]}, 32'h0);
        chk("s6_dis_wrap", {31'b0, wrap[0]}, 32'h0);
        repeat (10) step();
        chk("s6_dis_hold", {24'b0, phase[7:0]}, 32'h0);

        // Scenario 6b: out-of-range write
        write(5, 7, 1);
        step();
        chk("s6_oor_pend", {28'b0, pending}, 32'h0);
        repeat (5) step();

        // Scenario 6c: reset mid-period
        write(3, 2, 0);
        step();
        repeat (6) step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("s6_rst_phase", phase, 32'h0);
        chk("s6_rst_wrap", {28'b0, wrap}, 32'h0);
        chk("s6_rst_pending", {28'b0, pending}, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        repeat (5) step();

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                write(int'($urandom_range(0, 7)),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                                  : int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 99) == 0) sync = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_phase_gen.md
# multi_phase_gen

Parametrised, multi-channel frequency-to-phase generator. Each channel divides `clk` by a programmable period and advances a wrapping phase counter once per period, up or down. Period changes are glitch-free: they take effect only at the channel's next period boundary. A global `sync` aligns all channels. The block feeds per-channel phase words to the waveform lookup stages.

## Interface
- `CHANNELS`, 4: number of independent channels (1..16).
- `FREQ_W`, 13: width of the period word.
- `PHASE_W`, 8: width of each phase counter.
- `CH_W`, $clog2(CHANNELS) (min 1): channel address width.

- `clk`  in  1: single clock, all logic on rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `wr_en`  in  1: write strobe for the channel config.
- `wr_ch`  in  CH_W: target channel.
- `wr_freq`  in  FREQ_W: period word. 0 disables the channel.
- `wr_dir`  in  1: 0 counts up, 1 counts down.
- `sync`  in  1: synchronous pulse that realigns all channels.
- `phase`  out  CHANNELS*PHASE_W: packed phases, channel 0 in the LSBs.
- `wrap`  out  CHANNELS: 1-cycle pulse per channel on phase wrap.
- `pending`  out  CHANNELS: a shadow config is waiting to be applied.

## Operation
- **Per-channel state:** `shadow_{freq,dir}`, `pending`, `active_{freq,dir}`, divider `cnt` (FREQ_W bits) and `phase`.
- **Write:** `wr_en` with `wr_ch` < CHANNELS loads the shadow and sets `pending`. Writes with `wr_ch` >= CHANNELS are ignored. If several writes arrive before they are applied, the last one wins.
- **Tick:** when `active_freq` != 0 and `cnt == active_freq`, the next edge does all of the following:
  - sets `cnt` to 0;
  - steps `phase` by ±1 modulo 2^PHASE_W;
  - if `pending`, copies shadow to active and clears `pending`.
  
  Otherwise `cnt` increments. The period is therefore `active_freq`+1 cycles.
- **Disabled channel** (`active_freq` == 0):
  - `cnt` and `phase` are held at 0.
  - A pending shadow is applied on the next edge, and `cnt` restarts at 0.
- **Write coincident with a tick on the same channel:** the tick applies the old shadow, if one was pending. The new write lands in the shadow and stays pending until the following tick.
- **Writing freq 0 to a running channel:** it is applied at the next tick. On that edge `phase` goes to 0, `cnt` goes to 0 and `wrap` does not assert. The channel then stays idle.
- **`wrap`:** asserted on the tick edge where `phase` goes from all-ones to 0 (up) or from 0 to all-ones (down). It is registered and high for exactly one cycle.
- **`sync`:** on every channel, sets `cnt` and `phase` to 0 and applies any pending shadow. `wrap` is 0 that cycle.
  - Priority: `sync` > tick > idle count.
  - A `wr_en` in the same cycle as `sync` still updates the shadow and stays pending.

## Timing
- **Reset values:** all `phase` 0, `wrap` 0, `pending` 0. All `cnt`, active and shadow registers are 0, so every channel resets disabled.
- **Start-up latency:** write at edge t to a disabled channel gives active at t+1 and the first phase step at edge t+2+freq.
- **Steady state:** phase steps every freq+1 cycles.
- **Outputs:** `phase` and `wrap` change on the same edge. `pending` rises on the edge after `wr_en` and falls on the applying edge.
- **Reset mid-operation:** immediately returns everything to the reset values, including discarding pending shadows.
- **Arithmetic:** the ±1 phase step wraps silently. `cnt` never exceeds `active_freq`, because a shortened period is applied only at a boundary.

## Structure
- Package `phase_gen_pkg` holds the default widths (FREQ_W_DEF=13, PHASE_W_DEF=8) and the direction encodings DIR_UP=0, DIR_DN=1.
- Sub-module `phase_gen_chan` contains one channel's shadow, active, `cnt`, `phase` and wrap logic. The top instantiates it CHANNELS times, plus the write address decode and the output packing.

## Test plan
Parameters for all scenarios: CHANNELS=4, FREQ_W=13, PHASE_W=8.
1. Release `rst_n` -> `phase` = 0 on all channels; `wrap` = 0000; `pending` = 0000; `phase` stays 0 for 100 cycles.
2. Write ch0 freq=3, up, at edge t -> `pending[0]` high only during t+1; phase0 = 1 at t+5, then +1 every 4 cycles. Other channels stay 0.
3. Ch0 running at freq=3, write freq=1 two cycles after a tick -> the next step still comes 4 cycles after the previous one, then steps every 2 cycles. `pending[0]` clears on the applying tick.
4. Ch1 freq=0→1 (up) -> 256 ticks later phase1 goes 255→0 with `wrap[1]` high for exactly 1 cycle. Then write dir=down, freq=1 -> phase1 goes 0→255 with `wrap[1]` pulsing at the following wrap.
5. Channels 0-2 running at different periods, pulse `sync` -> on the next edge all phases = 0, `cnt` = 0 and `wrap` = 0000. Pending writes are applied, and steps realign to their respective periods.
6. Each of the following on a running channel:
   - Write freq=0 -> phase goes to 0 at the next tick, with no `wrap`.
   - Write with `wr_ch`=5 (out of range) -> no state change.
   - Assert `rst_n`=0 mid-period -> immediate return to the scenario-1 state.
